// File: rtl/mplx_pkg.sv
// Shared types and constants for the mplx scheduler slice.
package mplx_pkg;
    localparam int   RES_W    = 3;
    // Owner IDs double as the mplx sel encoding.
    localparam logic OWN_DICE = 1'b0;
    localparam logic OWN_TL   = 1'b1;

    typedef enum logic [2:0] {IDLE, SETTLE, RUN, CAP, RESP} state_t;
endpackage

// File: rtl/mplx_sched_if.sv
// Requester handshakes plus mplx drive lines for mplx_sched.
// MPLX_SCHED_CNT_EN adds the per-requester grant counters.
interface mplx_sched_if
    import mplx_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             dice_req, dice_gnt, dice_vld;
    logic             tl_req, tl_gnt, tl_vld;
    logic [RES_W-1:0] dice_val, tl_val;
    logic             mplx_sel, mplx_button;
    logic [RES_W-1:0] mplx_result;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

`ifdef MPLX_SCHED_CNT_EN
    logic [CNT_W-1:0] dice_cnt, tl_cnt;

    modport master (
        input  dice_req, tl_req, mplx_result,
        output dice_gnt, dice_val, dice_vld, tl_gnt, tl_val, tl_vld,
        output mplx_sel, mplx_button, dice_cnt, tl_cnt
    );
    modport slave (
        output dice_req, tl_req, mplx_result,
        input  dice_gnt, dice_val, dice_vld, tl_gnt, tl_val, tl_vld,
        input  mplx_sel, mplx_button, dice_cnt, tl_cnt
    );
`else
    modport master (
        input  dice_req, tl_req, mplx_result,
        output dice_gnt, dice_val, dice_vld, tl_gnt, tl_val, tl_vld,
        output mplx_sel, mplx_button
    );
    modport slave (
        output dice_req, tl_req, mplx_result,
        input  dice_gnt, dice_val, dice_vld, tl_gnt, tl_val, tl_vld,
        input  mplx_sel, mplx_button
    );
`endif
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant advances only on upd.
module rr_arb2
    import mplx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       win,
    output logic       req_any
);
    logic last_grant;

    always_comb begin
        req_any = |req;
        // On a tie the requester that did not win last time goes first.
        if (&req) win = ~last_grant;
        else      win = req[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      last_grant <= OWN_TL;
        else if (upd) last_grant <= win;
    end
endmodule

// File: rtl/mplx_sched.sv
// Shares the dice / traffic-light mplx between two requesters, round-robin.
// MPLX_SCHED_CNT_EN adds saturating grant counters dice_cnt / tl_cnt.
module mplx_sched
    import mplx_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ROLL_CYCLES   = 8,
    parameter int CNT_W         = 8
)(
    input  logic        clk,
    input  logic        rst,
    mplx_sched_if.master bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 1..15");
    end
    if (ROLL_CYCLES < 1 || ROLL_CYCLES > 255) begin : g_bad_roll
        $error("ROLL_CYCLES out of range 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ROLL_LD   = 8'(ROLL_CYCLES - 1);

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             sel, sel_nxt, btn, btn_nxt;
    logic             dgnt, dgnt_nxt, tgnt, tgnt_nxt;
    logic             dvld, dvld_nxt, tvld, tvld_nxt;
    logic [RES_W-1:0] dval, dval_nxt, tval, tval_nxt;
    logic             win, req_any, upd;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.tl_req, bus.dice_req}),
        .upd     (upd),
        .win     (win),
        .req_any (req_any)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        btn_nxt   = 1'b0;
        dgnt_nxt  = 1'b0;
        tgnt_nxt  = 1'b0;
        dvld_nxt  = 1'b0;
        tvld_nxt  = 1'b0;
        dval_nxt  = dval;
        tval_nxt  = tval;
        upd       = 1'b0;
        case (state)
            IDLE: if (req_any) begin
                upd       = 1'b1;
                owner_nxt = win;
                sel_nxt   = win;
                cnt_nxt   = SETTLE_LD;
                dgnt_nxt  = (win == OWN_DICE);
                tgnt_nxt  = (win == OWN_TL);
                state_nxt = SETTLE;
            end
            SETTLE: if (cnt == 8'd0) begin
                state_nxt = RUN;
                btn_nxt   = 1'b1;
                cnt_nxt   = (owner == OWN_DICE) ? ROLL_LD : 8'd0;
            end else begin
                cnt_nxt = cnt - 8'd1;
            end
            // btn is registered, so it is driven for the cycle after this one.
            RUN: if (cnt == 8'd0) begin
                state_nxt = CAP;
            end else begin
                btn_nxt = 1'b1;
                cnt_nxt = cnt - 8'd1;
            end
            CAP: begin
                state_nxt = RESP;
                if (owner == OWN_DICE) begin
                    dval_nxt = bus.mplx_result;
                    dvld_nxt = 1'b1;
                end else begin
                    tval_nxt = bus.mplx_result;
                    tvld_nxt = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_DICE;
            cnt   <= 8'd0;
            sel   <= OWN_DICE;
            btn   <= 1'b0;
            dgnt  <= 1'b0;
            tgnt  <= 1'b0;
            dvld  <= 1'b0;
            tvld  <= 1'b0;
            dval  <= '0;
            tval  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            btn   <= btn_nxt;
            dgnt  <= dgnt_nxt;
            tgnt  <= tgnt_nxt;
            dvld  <= dvld_nxt;
            tvld  <= tvld_nxt;
            dval  <= dval_nxt;
            tval  <= tval_nxt;
        end
    end

    assign bus.mplx_sel    = sel;
    assign bus.mplx_button = btn;
    assign bus.dice_gnt    = dgnt;
    assign bus.tl_gnt      = tgnt;
    assign bus.dice_vld    = dvld;
    assign bus.tl_vld      = tvld;
    assign bus.dice_val    = dval;
    assign bus.tl_val      = tval;

`ifdef MPLX_SCHED_CNT_EN
    logic [CNT_W-1:0] dcnt, tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
            tcnt <= '0;
        end else begin
            if (dgnt_nxt && !(&dcnt)) dcnt <= dcnt + 1'b1;
            if (tgnt_nxt && !(&tcnt)) tcnt <= tcnt + 1'b1;
        end
    end

    assign bus.dice_cnt = dcnt;
    assign bus.tl_cnt   = tcnt;
`endif
endmodule

// File: tb/tb_mplx_sched.sv
// Bench for mplx_sched: waveform table, directed corner sequences and a
// randomized run against a transaction-level latency/round-robin model.
module tb_mplx_sched;
    import mplx_pkg::*;

    localparam int S = 1;
    localparam int R = 8;
`ifdef MPLX_SCHED_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif
    localparam int NC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mplx_sched_if #(.CNT_W(CW)) bus ();
    mplx_sched #(.SETTLE_CYCLES(S), .ROLL_CYCLES(R), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural mplx: die cycles 1..6 per enabled clock, lights step once per pulse.
    function automatic logic [2:0] pat(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b100;
            2'd1:    return 3'b110;
            2'd2:    return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    logic [2:0] die;
    logic [1:0] tli;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            die <= 3'd1;
            tli <= 2'd0;
        end else if (bus.mplx_button) begin
            if (!bus.mplx_sel) die <= (die == 3'd6) ? 3'd1 : die + 3'd1;
            else               tli <= tli + 2'd1;
        end
    end
    assign bus.mplx_result = bus.mplx_sel ? pat(tli) : die;

    // Transaction-level model state.
    int   cyc, free_edge, n_vec, n_err;
    bit   exp_gd [NC], exp_gt [NC], exp_vd [NC], exp_vt [NC], exp_btn [NC], exp_sc [NC];
    logic exp_sv [NC];
    logic m_last, m_sel;
    logic [2:0] m_dval, m_tval, p_dval, p_tval, m_die;
    logic [1:0] m_tli;
    int   m_dcnt, m_tcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Decide a grant at the edge that closes the current cycle.
    task automatic model_edge();
        int  e, l;
        logic w;
        e = cyc;
        if (e >= free_edge && (bus.dice_req || bus.tl_req)) begin
            w = (bus.dice_req && bus.tl_req) ? ~m_last : bus.tl_req;
            m_last = w;
            exp_sc[e+1] = 1'b1;
            exp_sv[e+1] = w;
            if (w == OWN_DICE) begin
                l = S + R + 2;
                exp_gd[e+1] = 1'b1;
                exp_vd[e+l] = 1'b1;
                for (int c = e + S + 1; c <= e + S + R; c++) exp_btn[c] = 1'b1;
                m_die  = 3'((int'(m_die) - 1 + R) % 6 + 1);
                p_dval = m_die;
            end else begin
                l = S + 3;
                exp_gt[e+1] = 1'b1;
                exp_vt[e+l] = 1'b1;
                exp_btn[e+S+1] = 1'b1;
                m_tli  = m_tli + 2'd1;
                p_tval = pat(m_tli);
            end
            free_edge = e + l + 1;
        end
    endtask

    task automatic check_cycle();
        int c;
        c = cyc;
        if (exp_sc[c]) m_sel  = exp_sv[c];
        if (exp_vd[c]) m_dval = p_dval;
        if (exp_vt[c]) m_tval = p_tval;
        if (exp_gd[c] && m_dcnt < (2**CW - 1)) m_dcnt++;
        if (exp_gt[c] && m_tcnt < (2**CW - 1)) m_tcnt++;
        chk("dice_gnt", 32'(bus.dice_gnt), 32'(exp_gd[c]));
        chk("tl_gnt", 32'(bus.tl_gnt), 32'(exp_gt[c]));
        chk("dice_vld", 32'(bus.dice_vld), 32'(exp_vd[c]));
        chk("tl_vld", 32'(bus.tl_vld), 32'(exp_vt[c]));
        chk("mplx_button", 32'(bus.mplx_button), 32'(exp_btn[c]));
        chk("mplx_sel", 32'(bus.mplx_sel), 32'(m_sel));
        chk("dice_val", 32'(bus.dice_val), 32'(m_dval));
        chk("tl_val", 32'(bus.tl_val), 32'(m_tval));
`ifdef MPLX_SCHED_CNT_EN
        chk("dice_cnt", 32'(bus.dice_cnt), 32'(m_dcnt));
        chk("tl_cnt", 32'(bus.tl_cnt), 32'(m_tcnt));
`endif
    endtask

    task automatic step(input logic d, input logic t);
        bus.dice_req = d;
        bus.tl_req   = t;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    // Asserted just after an edge so its effect is visible in the same cycle.
    task automatic do_reset();
        bus.dice_req = 1'b0;
        bus.tl_req   = 1'b0;
        rst = 1'b1;
        for (int c = cyc; c < NC; c++) begin
            exp_gd[c] = 0; exp_gt[c] = 0; exp_vd[c] = 0; exp_vt[c] = 0;
            exp_btn[c] = 0; exp_sc[c] = 0; exp_sv[c] = 1'b0;
        end
        m_last = OWN_TL; m_sel = 1'b0; m_dval = 3'd0; m_tval = 3'd0;
        m_die = 3'd1; m_tli = 2'd0; m_dcnt = 0; m_tcnt = 0;
        #1;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        free_edge = cyc;
        check_cycle();
    endtask

    typedef struct {
        logic d, t, gd, gt, btn, sel, vd, vt;
    } vec_t;

    initial begin
        vec_t       tab [17];
        logic [2:0] cap;
        logic [2:0] tlseq [4];
        int         order [$];
        int         b;
        logic       got, pd, pt;

        n_vec = 0; n_err = 0; cyc = 0; free_edge = 0;
        bus.dice_req = 1'b0; bus.tl_req = 1'b0; rst = 1'b0;
        cap = 3'd0;
        #2;
        do_reset();

        // Reset in the middle of a dice roll: everything drops at once.
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("run_btn_before_rst", 32'(bus.mplx_button), 32'd1);
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0);

        // Dice roll then TL step; inputs before edge i, outputs for cycle i+1.
        for (int i = 0; i < 17; i++) tab[i] = '{default: 1'b0};
        tab[0].d = 1'b1; tab[0].gd = 1'b1;
        for (int i = 1; i <= 8; i++) tab[i].btn = 1'b1;
        tab[10].vd = 1'b1;
        tab[11].t = 1'b1; tab[12].t = 1'b1; tab[12].gt = 1'b1;
        for (int i = 12; i < 17; i++) tab[i].sel = 1'b1;
        tab[13].btn = 1'b1;
        tab[15].vt = 1'b1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tab[i].d, tab[i].t);
            chk("tab_dgnt", 32'(bus.dice_gnt), 32'(tab[i].gd));
            chk("tab_tgnt", 32'(bus.tl_gnt), 32'(tab[i].gt));
            chk("tab_btn", 32'(bus.mplx_button), 32'(tab[i].btn));
            chk("tab_sel", 32'(bus.mplx_sel), 32'(tab[i].sel));
            chk("tab_dvld", 32'(bus.dice_vld), 32'(tab[i].vd));
            chk("tab_tvld", 32'(bus.tl_vld), 32'(tab[i].vt));
            if (i == 9)  cap = bus.mplx_result;
            if (i == 10) chk("dice_val_vs_result", 32'(bus.dice_val), 32'(cap));
        end

        // Four TL steps walk the light sequence from reset.
        tlseq[0] = 3'b110; tlseq[1] = 3'b001; tlseq[2] = 3'b010; tlseq[3] = 3'b100;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b = 0; got = 1'b0;
            while (!got && b < 10) begin step(1'b0, 1'b1); b++; got = bus.tl_gnt; end
            chk("tl_gnt_seen", 32'(got), 32'd1);
            b = 0;
            while (!bus.tl_vld && b < 10) begin step(1'b0, 1'b0); b++; end
            chk("tl_vld_seen", 32'(bus.tl_vld), 32'd1);
            chk("tl_pattern", 32'(bus.tl_val), 32'(tlseq[k]));
        end

        // Both held from reset: dice first, then strict alternation.
        do_reset();
        order.delete();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1);
            if (bus.dice_gnt) order.push_back(0);
            if (bus.tl_gnt)   order.push_back(1);
        end
        chk("alt_count_ge4", 32'(order.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk("alt_order", 32'(order[k]), 32'(k % 2));

        // Request dropped one cycle after grant still completes.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        b = 0;
        while (!bus.dice_vld && b < 20) begin step(1'b0, 1'b0); b++; end
        chk("drop_after_gnt_vld", 32'(bus.dice_vld), 32'd1);

`ifdef MPLX_SCHED_CNT_EN
        begin
            int exp_cnt [5] = '{1, 2, 3, 3, 3};
            do_reset();
            for (int k = 0; k < 5; k++) begin
                b = 0; got = 1'b0;
                while (!got && b < 10) begin step(1'b1, 1'b0); b++; got = bus.dice_gnt; end
                chk("cnt_gnt_seen", 32'(got), 32'd1);
                chk("dice_cnt_seq", 32'(bus.dice_cnt), 32'(exp_cnt[k]));
                chk("tl_cnt_zero", 32'(bus.tl_cnt), 32'd0);
                b = 0;
                while (!bus.dice_vld && b < 20) begin step(1'b0, 1'b0); b++; end
            end
        end
`endif

        // Random requests, occasionally withdrawn before grant, one reset midway.
        do_reset();
        pd = 1'b0; pt = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
                pd = 1'b0; pt = 1'b0;
            end
            if (!pd && $urandom_range(3) == 0) pd = 1'b1;
            else if (pd && $urandom_range(15) == 0) pd = 1'b0;
            if (!pt && $urandom_range(3) == 0) pt = 1'b1;
            else if (pt && $urandom_range(15) == 0) pt = 1'b0;
            step(pd, pt);
            if (bus.dice_gnt) pd = 1'b0;
            if (bus.tl_gnt)   pt = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
